// File: rtl/fetch_redirect_if.sv
// Fetch-redirect control bus: master = redirect controller, slave = fetch/execute side.
// Pure wiring; no latency or flow control of its own.
interface fetch_redirect_if #(
  parameter int PC_W = 32
);
  logic            int_req;
  logic            hazard_stall;
  logic            is_two_word;
  logic [PC_W-1:0] pc_current;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            rti_exec;

  logic            stall;
  logic            jumpBit;
  logic [PC_W-1:0] branchIR;
  logic            interruptBit;
  logic            flush;
  logic            int_ack;
  logic            in_isr;
  logic [PC_W-1:0] saved_pc;

  modport master (
    input  int_req, hazard_stall, is_two_word, pc_current,
           branch_taken, branch_target, rti_exec,
    output stall, jumpBit, branchIR, interruptBit, flush,
           int_ack, in_isr, saved_pc
  );

  modport slave (
    output int_req, hazard_stall, is_two_word, pc_current,
           branch_taken, branch_target, rti_exec,
    input  stall, jumpBit, branchIR, interruptBit, flush,
           int_ack, in_isr, saved_pc
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect/hold controller: branch and RTI redirects one cycle after the request, interrupt entry after DRAIN_CYCLES of hold.
// stall is combinational (hazard_stall or draining); INT_EDGE_EN selects edge-triggered instead of level interrupt latching.
module fetch_redirect_ctrl #(
  parameter int PC_W         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  fetch_redirect_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2,
    ISR    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic            pending;
  logic            int_set;
  logic            enter_ok;
  logic [PC_W-1:0] saved_pc_q;
  logic [PC_W-1:0] branch_ir_q;
  logic            jump_q;
  logic            int_bit_q;
  logic            flush_q;
  logic            ack_q;
  logic            in_isr_q;

`ifdef INT_EDGE_EN
  logic int_req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= bus.int_req;
    end
  end

  assign int_set = bus.int_req & ~int_req_q;
`else
  assign int_set = bus.int_req;
`endif

  // Entry only at a clean instruction boundary; a same-cycle branch keeps priority.
  assign enter_ok = pending & ~bus.is_two_word & ~bus.hazard_stall & ~bus.branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      pending     <= 1'b0;
      saved_pc_q  <= '0;
      branch_ir_q <= '0;
      jump_q      <= 1'b0;
      int_bit_q   <= 1'b0;
      flush_q     <= 1'b0;
      ack_q       <= 1'b0;
      in_isr_q    <= 1'b0;
    end else begin
      jump_q    <= 1'b0;
      int_bit_q <= 1'b0;
      flush_q   <= 1'b0;
      ack_q     <= 1'b0;
      pending   <= (state == VECTOR) ? 1'b0 : (pending | int_set);

      case (state)
        IDLE: begin
          in_isr_q <= 1'b0;
          if (bus.branch_taken) begin
            jump_q      <= 1'b1;
            branch_ir_q <= bus.branch_target;
            flush_q     <= 1'b1;
          end else if (enter_ok) begin
            state      <= DRAIN;
            saved_pc_q <= bus.pc_current;
            cnt        <= CNT_INIT;
            flush_q    <= 1'b1;
          end
        end

        DRAIN: begin
          flush_q <= 1'b1;
          if (cnt == 4'd0) begin
            state     <= VECTOR;
            int_bit_q <= 1'b1;
            ack_q     <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        VECTOR: begin
          state    <= ISR;
          in_isr_q <= 1'b1;
        end

        ISR: begin
          if (bus.rti_exec) begin
            state       <= IDLE;
            in_isr_q    <= 1'b0;
            jump_q      <= 1'b1;
            branch_ir_q <= saved_pc_q;
            flush_q     <= 1'b1;
          end else begin
            in_isr_q <= 1'b1;
            if (bus.branch_taken) begin
              jump_q      <= 1'b1;
              branch_ir_q <= bus.branch_target;
              flush_q     <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall        = bus.hazard_stall | (state == DRAIN);
  assign bus.jumpBit      = jump_q;
  assign bus.branchIR     = branch_ir_q;
  assign bus.interruptBit = int_bit_q;
  assign bus.flush        = flush_q;
  assign bus.int_ack      = ack_q;
  assign bus.in_isr       = in_isr_q;
  assign bus.saved_pc     = saved_pc_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (DRAIN_CYCLES >= 1 && DRAIN_CYCLES <= 15);
      assert (!(jump_q && int_bit_q));
      assert (ack_q == (state == VECTOR));
      assert (in_isr_q == (state == ISR));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; ctl packs {stall, jumpBit, interruptBit, flush, int_ack, in_isr}.
module tb_fetch_redirect_ctrl;
  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_redirect_if #(.PC_W(PC_W)) bus ();

  fetch_redirect_ctrl #(.PC_W(PC_W), .DRAIN_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [5:0] ctl;
  assign ctl = {bus.stall, bus.jumpBit, bus.interruptBit, bus.flush, bus.int_ack, bus.in_isr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.int_req       = 1'b0;
    bus.hazard_stall  = 1'b0;
    bus.is_two_word   = 1'b0;
    bus.pc_current    = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.rti_exec      = 1'b0;
  endtask

  // Called the cycle after DRAIN entry is observed: drain, vector, ISR, then return.
  task automatic leave_via_rti();
    step(); step(); step();
    bus.rti_exec = 1'b1;
    step();
    bus.rti_exec = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 6'b000000); end
    n_cmp++; if (bus.saved_pc !== 32'h0) begin n_bad++; $display("FAIL reset_saved_pc: got %h want %h", bus.saved_pc, 32'h0); end
    n_cmp++; if (bus.branchIR !== 32'h0) begin n_bad++; $display("FAIL reset_branchIR: got %h want %h", bus.branchIR, 32'h0); end
    rst = 1'b0;
    bus.hazard_stall = 1'b1;
    #1;
    n_cmp++; if (ctl !== 6'b100000) begin n_bad++; $display("FAIL reset_hazard_stall: got %b want %b", ctl, 6'b100000); end
    bus.hazard_stall = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL reset_idle: got %b want %b", ctl, 6'b000000); end
  endtask

  task automatic test_branch();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0040;
    step();
    n_cmp++; if (ctl !== 6'b010100) begin n_bad++; $display("FAIL branch_ctl: got %b want %b", ctl, 6'b010100); end
    n_cmp++; if (bus.branchIR !== 32'h40) begin n_bad++; $display("FAIL branch_target: got %h want %h", bus.branchIR, 32'h40); end
    bus.branch_taken = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL branch_one_cycle: got %b want %b", ctl, 6'b000000); end
  endtask

  task automatic test_interrupt();
    bus.pc_current = 32'h0000_0024;
    bus.int_req    = 1'b1;
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL int_latch: got %b want %b", ctl, 6'b000000); end
    bus.int_req = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL int_drain1: got %b want %b", ctl, 6'b100100); end
    n_cmp++; if (bus.saved_pc !== 32'h24) begin n_bad++; $display("FAIL int_saved_pc: got %h want %h", bus.saved_pc, 32'h24); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_00AA;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL int_drain2: got %b want %b", ctl, 6'b100100); end
    n_cmp++; if (bus.branchIR !== 32'h40) begin n_bad++; $display("FAIL int_drain_branch_ignored: got %h want %h", bus.branchIR, 32'h40); end
    bus.branch_taken = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b001110) begin n_bad++; $display("FAIL int_vector: got %b want %b", ctl, 6'b001110); end
    step();
    n_cmp++; if (ctl !== 6'b000001) begin n_bad++; $display("FAIL int_isr: got %b want %b", ctl, 6'b000001); end
    step();
    n_cmp++; if (ctl !== 6'b000001) begin n_bad++; $display("FAIL int_isr_hold: got %b want %b", ctl, 6'b000001); end
    bus.rti_exec = 1'b1;
    step();
    n_cmp++; if (ctl !== 6'b010100) begin n_bad++; $display("FAIL rti_ctl: got %b want %b", ctl, 6'b010100); end
    n_cmp++; if (bus.branchIR !== 32'h24) begin n_bad++; $display("FAIL rti_target: got %h want %h", bus.branchIR, 32'h24); end
    bus.rti_exec = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL rti_done: got %b want %b", ctl, 6'b000000); end
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL int_no_reentry: got %b want %b", ctl, 6'b000000); end
  endtask

  task automatic test_two_word();
    bus.pc_current  = 32'h0000_0030;
    bus.int_req     = 1'b1;
    bus.is_two_word = 1'b1;
    step();
    bus.int_req = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL two_word_defer: got %b want %b", ctl, 6'b000000); end
    bus.is_two_word = 1'b0;
    bus.pc_current  = 32'h0000_0038;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL two_word_entry: got %b want %b", ctl, 6'b100100); end
    n_cmp++; if (bus.saved_pc !== 32'h38) begin n_bad++; $display("FAIL two_word_saved_pc: got %h want %h", bus.saved_pc, 32'h38); end
    leave_via_rti();
  endtask

  task automatic test_branch_vs_int();
    bus.pc_current    = 32'h0000_0050;
    bus.int_req       = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0080;
    step();
    n_cmp++; if (ctl !== 6'b010100) begin n_bad++; $display("FAIL bvi_branch_first: got %b want %b", ctl, 6'b010100); end
    n_cmp++; if (bus.branchIR !== 32'h80) begin n_bad++; $display("FAIL bvi_target: got %h want %h", bus.branchIR, 32'h80); end
    bus.int_req      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.pc_current   = 32'h0000_0080;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL bvi_entry: got %b want %b", ctl, 6'b100100); end
    n_cmp++; if (bus.saved_pc !== 32'h80) begin n_bad++; $display("FAIL bvi_saved_pc: got %h want %h", bus.saved_pc, 32'h80); end
    leave_via_rti();
  endtask

  task automatic test_hazard();
    bus.pc_current   = 32'h0000_0010;
    bus.int_req      = 1'b1;
    bus.hazard_stall = 1'b1;
    step();
    n_cmp++; if (ctl !== 6'b100000) begin n_bad++; $display("FAIL hz_latch: got %b want %b", ctl, 6'b100000); end
    bus.int_req = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b100000) begin n_bad++; $display("FAIL hz_wait: got %b want %b", ctl, 6'b100000); end
    bus.hazard_stall = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL hz_entry: got %b want %b", ctl, 6'b100100); end
    n_cmp++; if (bus.saved_pc !== 32'h10) begin n_bad++; $display("FAIL hz_saved_pc: got %h want %h", bus.saved_pc, 32'h10); end
    bus.hazard_stall = 1'b1;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL hz_drain_runs: got %b want %b", ctl, 6'b100100); end
    step();
    n_cmp++; if (ctl !== 6'b101110) begin n_bad++; $display("FAIL hz_vector_on_time: got %b want %b", ctl, 6'b101110); end
    bus.hazard_stall = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b000001) begin n_bad++; $display("FAIL hz_isr: got %b want %b", ctl, 6'b000001); end
    bus.rti_exec = 1'b1;
    step();
    bus.rti_exec = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    bus.pc_current = 32'h0000_0044;
    bus.int_req    = 1'b1;
    step();
    bus.int_req = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL abort_entry: got %b want %b", ctl, 6'b100100); end
    rst = 1'b1;
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL abort_reset_ctl: got %b want %b", ctl, 6'b000000); end
    n_cmp++; if (bus.saved_pc !== 32'h0) begin n_bad++; $display("FAIL abort_saved_pc: got %h want %h", bus.saved_pc, 32'h0); end
    rst = 1'b0;
    step(); step(); step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL abort_no_ack: got %b want %b", ctl, 6'b000000); end
  endtask

  task automatic test_nested();
    bus.pc_current = 32'h0000_0020;
    bus.int_req    = 1'b1;
    step();
    bus.int_req = 1'b0;
    step(); step(); step(); step();
    n_cmp++; if (ctl !== 6'b000001) begin n_bad++; $display("FAIL nest_in_isr: got %b want %b", ctl, 6'b000001); end
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    n_cmp++; if (ctl !== 6'b000001) begin n_bad++; $display("FAIL nest_no_ack: got %b want %b", ctl, 6'b000001); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0070;
    step();
    n_cmp++; if (ctl !== 6'b010101) begin n_bad++; $display("FAIL isr_branch: got %b want %b", ctl, 6'b010101); end
    n_cmp++; if (bus.branchIR !== 32'h70) begin n_bad++; $display("FAIL isr_branch_target: got %h want %h", bus.branchIR, 32'h70); end
    bus.branch_target = 32'h0000_0090;
    bus.rti_exec      = 1'b1;
    step();
    n_cmp++; if (ctl !== 6'b010100) begin n_bad++; $display("FAIL rti_wins_ctl: got %b want %b", ctl, 6'b010100); end
    n_cmp++; if (bus.branchIR !== 32'h20) begin n_bad++; $display("FAIL rti_wins_target: got %h want %h", bus.branchIR, 32'h20); end
    bus.rti_exec     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.pc_current   = 32'h0000_0034;
    step();
    n_cmp++; if (ctl !== 6'b100100) begin n_bad++; $display("FAIL nest_reentry: got %b want %b", ctl, 6'b100100); end
    n_cmp++; if (bus.saved_pc !== 32'h34) begin n_bad++; $display("FAIL nest_saved_pc: got %h want %h", bus.saved_pc, 32'h34); end
    step(); step();
    n_cmp++; if (ctl !== 6'b001110) begin n_bad++; $display("FAIL nest_second_ack: got %b want %b", ctl, 6'b001110); end
    step();
    bus.rti_exec = 1'b1;
    step();
    bus.rti_exec = 1'b0;
    step();
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL nest_done: got %b want %b", ctl, 6'b000000); end
  endtask

  // Held-high request with the handler returning as soon as it starts.
  // Level mode re-enters every 5 cycles (acks at edges 4, 9, 14, 19, 24); edge mode acks once.
  task automatic test_held();
    int acks;
    int want;
`ifdef INT_EDGE_EN
    want = 1;
`else
    want = 5;
`endif
    acks = 0;
    bus.int_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 24) bus.int_req = 1'b0;
      step();
      if (bus.int_ack === 1'b1) acks++;
      bus.rti_exec = bus.in_isr;
    end
    bus.rti_exec = 1'b0;
    n_cmp++; if (acks !== want) begin n_bad++; $display("FAIL held_ack_count: got %0d want %0d", acks, want); end
    n_cmp++; if (ctl !== 6'b000000) begin n_bad++; $display("FAIL held_settled: got %b want %b", ctl, 6'b000000); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_interrupt();
    test_two_word();
    test_branch_vs_int();
    test_hazard();
    test_reset_abort();
    test_nested();
    test_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Control-side counterpart of the fetch stage. It generates every redirect and hold request the fetch stage consumes: stall, jumpBit, branchIR and interruptBit. It sequences interrupt entry and return (latch, wait for instruction boundary, drain, vector, RTI), forwards taken branches from execute, and raises a pipeline flush for the IF/ID register.

Parameters:
PC_W, 32, width of PC and redirect target
DRAIN_CYCLES, 2, cycles fetch is held and IF/ID flushed before vectoring (range 1..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
int_req  in  1  external interrupt request
hazard_stall  in  1  load-use stall from decode hazard unit
is_two_word  in  1  instruction currently in fetch carries a trailing immediate word
pc_current  in  PC_W  current fetch PC (fetch samePc)
branch_taken  in  1  execute resolved a taken branch/jump this cycle
branch_target  in  PC_W  target of that branch
rti_exec  in  1  execute is retiring an RTI this cycle
stall  out  1  hold PC and instruction memory
jumpBit  out  1  select branchIR as next PC
branchIR  out  PC_W  redirect target
interruptBit  out  1  force PC to interrupt vector 0
flush  out  1  squash IF/ID contents
int_ack  out  1  one-cycle acknowledge to interrupt source
in_isr  out  1  handler executing
saved_pc  out  PC_W  return address captured at interrupt entry

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; pending=0, saved_pc=0, branchIR=0; jumpBit, interruptBit, flush, int_ack, in_isr registered 0. Reset mid-sequence aborts it with no ack.
- stall = hazard_stall OR (state==DRAIN), combinational; all other outputs registered.
- Interrupt latch: int_req=1 sets pending. Pending is cleared only in VECTOR. It stays set while in_isr (no nesting) and is serviced after return.
- Branch: branch_taken at edge N gives jumpBit=1, branchIR=branch_target, flush=1 during cycle N+1 for exactly one cycle. Honoured in IDLE and ISR. In DRAIN/VECTOR it is ignored: the squash covers it.
- States:
  IDLE: enter DRAIN when pending & !is_two_word & !hazard_stall & !branch_taken. On entry saved_pc<=pc_current and cnt<=DRAIN_CYCLES-1. A simultaneous branch wins and the interrupt is deferred, pending kept. is_two_word=1 defers entry so the immediate word is never split.
  DRAIN: flush=1, stall=1; cnt decrements; at cnt==0 go to VECTOR.
  VECTOR: interruptBit=1, int_ack=1, flush=1 for one cycle; pending<=0; go to ISR.
  ISR: in_isr=1. rti_exec at edge N gives jumpBit=1, branchIR=saved_pc, flush=1 in cycle N+1, then IDLE with in_isr=0 from N+1. rti_exec and branch_taken together: RTI wins.
- hazard_stall does not freeze DRAIN counting; interrupt entry only waits on it in IDLE.
- Outputs jumpBit and interruptBit are never 1 in the same cycle.

Optional Feature:
INT_EDGE_EN
- Defined: pending sets only on a 0->1 edge of int_req, using a registered copy of int_req that is cleared on reset. A held-high line is serviced once.
- Undefined: level-sensitive. If int_req is still 1 on return to IDLE, it re-enters.

Test Plan:
1. rst=1 two cycles, then idle inputs -> all outputs 0, stall=hazard_stall, state IDLE.
2. branch_taken=1, branch_target=0x0000_0040 at cycle 5 -> cycle 6: jumpBit=1, branchIR=0x40, flush=1; cycle 7 all low.
3. pc_current=0x0000_0024, int_req pulse, is_two_word=0 -> saved_pc=0x24. stall and flush high for DRAIN_CYCLES=2 cycles, then interruptBit=1 and int_ack=1 for one cycle, then in_isr=1. rti_exec later -> next cycle jumpBit=1, branchIR=0x24, in_isr falls.
4. int_req with is_two_word=1 for 1 cycle, then 0 -> entry delayed one cycle; saved_pc equals the PC after the two-word instruction.
5. int_req and branch_taken (target 0x80) in the same cycle -> branch redirect first. Interrupt entry next cycle with saved_pc=pc_current (0x80).
6. Second int_req while in_isr -> no ack until after RTI. After return it re-enters and int_ack pulses again. With INT_EDGE_EN and int_req held high, only one ack occurs.
